sobel_mag_serial: RTL and testbench

- Bit-serial gradient-magnitude stage of the sobel datapath.
- Accepts one signed Gx/Gy pair per transaction and computes |Gx|+|Gy|, LSB first, one bit per cycle.
- Each bit passes through a single instance of the one-bit full-adder cell (fa), with the carry held in a flop.
- Saturates the result to an unsigned pixel and presents it on a valid/ready output towards the pixel writer.

---
 rtl/sobel_mag_serial_if.sv | 24 ++
 rtl/sobel_mag_serial.sv | 131 +++++++++++++
 tb/tb_sobel_mag_serial.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_mag_serial_if.sv
// Handshake bundle between the gradient source, the serial magnitude stage
// and the pixel writer. The slave modport is the magnitude stage itself.
interface sobel_mag_serial_if #(
  parameter int W     = 11,
  parameter int OUT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     gx;
  logic [W-1:0]     gy;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] mag;

  modport master (
    output in_valid, gx, gy, out_ready,
    input  in_ready, out_valid, mag
  );

  modport slave (
    input  in_valid, gx, gy, out_ready,
    output in_ready, out_valid, mag
  );
endinterface

// File: rtl/sobel_mag_serial.sv
// Bit-serial |gx|+|gy| for the sobel datapath. The two magnitudes are added
// LSB first through one full-adder cell, then saturated to an unsigned pixel.

module fa (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

// state | meaning
// IDLE  | ready for a gx/gy pair
// ABS   | convert captured operands to unsigned magnitudes
// ADD   | W serial add cycles through the fa cell
// SAT   | clamp the W+1 bit sum to OUT_W bits
// HOLD  | present mag until the writer accepts it
module sobel_mag_serial #(
  parameter int W     = 11,
  parameter int OUT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  sobel_mag_serial_if.slave  bus,
  output logic               busy
);
  typedef enum logic [2:0] {IDLE, ABS, ADD, SAT, HOLD} state_t;

  localparam int           CW      = $clog2(W + 1);
  localparam logic [W:0]   SAT_MAX = (W + 1)'((1 << OUT_W) - 1);

  state_t           state, next;
  logic [W-1:0]     gx_q, gy_q;
  logic [W-1:0]     a_q, b_q;
  logic [W-1:0]     sum_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [OUT_W-1:0] mag_q;

  logic [W-1:0]     abs_gx, abs_gy;
  logic [W:0]       full_sum;
  logic             fa_s, fa_c;

  // Most negative input maps to 2^(W-1), which still fits W unsigned bits.
  assign abs_gx   = gx_q[W-1] ? -gx_q : gx_q;
  assign abs_gy   = gy_q[W-1] ? -gy_q : gy_q;
  assign full_sum = {carry_q, sum_q};

  fa u_fa (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .c_in  (carry_q),
    .s     (fa_s),
    .c_out (fa_c)
  );

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  // Next-state and handshake outputs decoded from the current state.
  always_comb begin
    next          = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b1;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        busy         = 1'b0;
        if (bus.in_valid) next = ABS;
      end
      ABS:  next = ADD;
      ADD:  if (cnt_q == CW'(W - 1)) next = SAT;
      SAT:  next = HOLD;
      HOLD: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // Operand capture, serial add through fa, and saturation into mag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_q    <= '0;
      gy_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      mag_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            gx_q <= bus.gx;
            gy_q <= bus.gy;
          end
        end
        ABS: begin
          a_q     <= abs_gx;
          b_q     <= abs_gy;
          carry_q <= 1'b0;
          cnt_q   <= '0;
        end
        ADD: begin
          sum_q   <= {fa_s, sum_q[W-1:1]};
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= fa_c;
          cnt_q   <= cnt_q + CW'(1);
        end
        SAT: begin
          if (full_sum > SAT_MAX) mag_q <= '1;
          else                    mag_q <= full_sum[OUT_W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.mag = mag_q;
endmodule

// File: tb/tb_sobel_mag_serial.sv
// Scoreboard bench for sobel_mag_serial: accepted pairs push a reference
// magnitude, a monitor thread pops and compares on each output handshake and
// also watches latency, hold stability and the post-handshake in_ready rise.
module tb_sobel_mag_serial;
  localparam int W      = 11;
  localparam int OUT_W  = 8;
  localparam int LAT    = W + 2;
  localparam int PERIOD = W + 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  sobel_mag_serial_if #(.W(W), .OUT_W(OUT_W)) bus ();

  sobel_mag_serial #(.W(W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int hs_q[$];
  int out_cyc[$];

  function automatic int model(input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy, m, lim;
    sx  = int'($signed(x));
    sy  = int'($signed(y));
    lim = (1 << OUT_W) - 1;
    if (sx < 0) sx = -sx;
    if (sy < 0) sy = -sy;
    m = sx + sy;
    return (m > lim) ? lim : m;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm, input string why);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s (cycle %0d)", nm, why, cyc);
  endtask

  task automatic monitor();
    logic ov_prev, rdy_prev, post_hs;
    int   mag_prev;
    ov_prev  = 1'b0;
    rdy_prev = 1'b0;
    post_hs  = 1'b0;
    mag_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        hs_q.delete();
        ov_prev  = 1'b0;
        rdy_prev = 1'b0;
        post_hs  = 1'b0;
      end else begin
        if (post_hs) begin
          check("in_ready_after_out", int'(bus.in_ready), 1);
          check("out_valid_pulse", int'(bus.out_valid), 0);
        end
        post_hs = 1'b0;
        if (bus.out_valid && !ov_prev) begin
          if (hs_q.size() == 0) fail("spurious_out_valid", "no transaction pending");
          else check("latency", cyc - hs_q[0], LAT);
        end
        if (ov_prev && !rdy_prev) begin
          check("hold_valid", int'(bus.out_valid), 1);
          check("hold_mag", int'(bus.mag), mag_prev);
          check("hold_in_ready", int'(bus.in_ready), 0);
          check("hold_busy", int'(busy), 1);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) fail("mag", "output with empty scoreboard");
          else begin
            check("mag", int'(bus.mag), exp_q.pop_front());
            void'(hs_q.pop_front());
          end
          out_cyc.push_back(cyc + 1);
          post_hs = 1'b1;
        end
        if (bus.in_valid && bus.in_ready) begin
          exp_q.push_back(model(bus.gx, bus.gy));
          hs_q.push_back(cyc + 1);
        end
        ov_prev  = bus.out_valid;
        rdy_prev = bus.out_ready;
        mag_prev = int'(bus.mag);
      end
    end
  endtask

  // Called just after a rising edge; returns just after the handshake edge.
  task automatic send(input int x, input int y, input bit keep);
    int t;
    t = 0;
    bus.gx       = W'(x);
    bus.gy       = W'(y);
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) fail("send_timeout", "in_ready never rose");
    @(posedge clk);
    #1;
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) fail("drain_timeout", "result never delivered");
    @(posedge clk);
    #1;
  endtask

  int dx[6] = '{100, 0, -1, -1024, 200, 200};
  int dy[6] = '{-50, 0,  1,  1023,  55,  56};

  initial begin
    int base, t;
    bus.in_valid  = 1'b0;
    bus.gx        = '0;
    bus.gy        = '0;
    bus.out_ready = 1'b1;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", int'(bus.in_ready), 1);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_mag", int'(bus.mag), 0);
    check("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      send(dx[i], dy[i], 1'b0);
      drain();
    end

    // Backpressure with a competing pair presented while busy.
    bus.out_ready = 1'b0;
    send(30, -40, 1'b0);
    t = 0;
    while (!bus.out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) fail("bp_wait", "out_valid never rose");
    @(posedge clk);
    #1;
    bus.gx       = W'(5);
    bus.gy       = W'(5);
    bus.in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(5, 5, 1'b0);
    drain();

    // Back-to-back with in_valid held high.
    base = out_cyc.size();
    send(10, 10, 1'b1);
    send(-300, -300, 1'b1);
    send(7, -8, 1'b0);
    drain();
    if (out_cyc.size() < base + 3) fail("b2b_count", "fewer than 3 outputs");
    else begin
      check("b2b_gap0", out_cyc[base + 1] - out_cyc[base], PERIOD);
      check("b2b_gap1", out_cyc[base + 2] - out_cyc[base + 1], PERIOD);
    end

    // Asynchronous reset in the middle of the serial add.
    send(300, 400, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_in_ready", int'(bus.in_ready), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_mag", int'(bus.mag), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    send(-7, 9, 1'b0);
    drain();

    // Random pairs over the full signed range with occasional stalls.
    for (int i = 0; i < 40; i++) begin
      int x, y;
      x = int'($urandom_range(0, (1 << W) - 1));
      y = int'($urandom_range(0, (1 << W) - 1));
      bus.out_ready = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      send(x, y, 1'b0);
      if (!bus.out_ready) begin
        repeat ($urandom_range(LAT, LAT + 6)) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
      drain();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
